// File: rtl/delta_sigma_decoder_pkg.sv
// Shared delta-sigma definitions: FSM state encodings used by the decoder and the DAC.
package delta_sigma_decoder_pkg;

  typedef enum logic {
    FLUSH = 1'b0,
    ACCUM = 1'b1
  } ds_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; all stages clear on reset.
module bit_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/delta_sigma_decoder.sv
// Delta-sigma bitstream decoder: counts ones over 2^WIDTH-cycle windows after a
// synchronizer flush and strobes the saturated count out once per window.
module delta_sigma_decoder
  import delta_sigma_decoder_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             DS_in,
  output logic [WIDTH-1:0] ADC_out,
  output logic             ADC_valid
);

  localparam int                 FLUSH_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES - 1);
  localparam logic [WIDTH-1:0]   WIN_LAST   = '1;

  logic ds_s;

  ds_state_e          state_q, state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WIDTH-1:0]   win_cnt_q, win_cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH:0]     acc_sum;
  logic [WIDTH-1:0]   adc_out_q, adc_out_d;
  logic               adc_valid_q, adc_valid_d;

  // A full window of ones reaches exactly 2^WIDTH, the only value with the top bit set.
  function automatic logic [WIDTH-1:0] sat_window(input logic [WIDTH:0] v);
    if (v[WIDTH]) begin
      return '1;
    end
    return v[WIDTH-1:0];
  endfunction

  bit_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (DS_in),
    .q  (ds_s)
  );

  assign acc_sum = acc_q + {{WIDTH{1'b0}}, ds_s};

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    adc_out_d   = adc_out_q;
    adc_valid_d = 1'b0;
    case (state_q)
      FLUSH: begin
        win_cnt_d = '0;
        acc_d     = '0;
        if (flush_cnt_q == FLUSH_LAST) begin
          flush_cnt_d = '0;
          state_d     = ACCUM;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      ACCUM: begin
        // clr outranks a completing window so a restart never emits a partial result.
        if (clr) begin
          win_cnt_d = '0;
          acc_d     = '0;
        end else if (en) begin
          if (win_cnt_q == WIN_LAST) begin
            adc_out_d   = sat_window(acc_sum);
            adc_valid_d = 1'b1;
            acc_d       = '0;
            win_cnt_d   = '0;
          end else begin
            acc_d     = acc_sum;
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      adc_out_q   <= '0;
      adc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      adc_out_q   <= adc_out_d;
      adc_valid_q <= adc_valid_d;
    end
  end

  assign ADC_out   = adc_out_q;
  assign ADC_valid = adc_valid_q;

endmodule
